raster_addr_gen: RTL
====================

# raster_addr_gen

Parametrised raster-scan address generator for the pixel pipeline. Produces per-pixel X/Y coordinates and a linear frame-buffer address over a runtime-configurable frame, with a valid/ready handshake so downstream pixel compute can stall it. Supports single-shot and continuous (free-running) frame modes. Optional start/end-of-line and start/end-of-frame flags.

## Interface
- X_W, 10: width of X coordinate; max line length 2^X_W.
- Y_W, 10: width of Y coordinate; max frame height 2^Y_W.
- A_W, X_W+Y_W: width of linear address.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins a scan when in IDLE, ignored otherwise.
- cont  in  1  sampled with start: 1 = continuous frames, 0 = single frame.
- stop  in  1  level; when high at end of a frame, return to IDLE after that frame.
- h_last  in  X_W  last X index (line length minus 1), sampled at frame start.
- v_last  in  Y_W  last Y index (frame height minus 1), sampled at frame start.
- out_valid  out  1  coordinate/address outputs valid.
- out_ready  in  1  downstream accepts current beat.
- x  out  X_W  current X.
- y  out  Y_W  current Y.
- addr  out  A_W  linear address = y*(h_last+1)+x, kept by running increment (no multiplier).
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse after last beat of a scan that returns to IDLE.
- sol, eol, sof, eof  out  1 each  (only with flags macro) start/end of line, start/end of frame, aligned to the beat.

## Operation
- States: IDLE, SCAN.
- IDLE: out_valid=0, busy=0. On start: latch h_last, v_last, cont; x=0, y=0, addr=0; go SCAN.
- SCAN: out_valid=1. Beat accepted when out_valid && out_ready; outputs only change on accepted beat. Stall holds x/y/addr/flags stable.
- Accepted beat, x<h_last: x+1, addr+1.
- Accepted beat, x==h_last, y<v_last: x=0, y+1, addr+1.
- Accepted beat, x==h_last, y==v_last (last beat):
  - if cont=1 and stop=0: relatch h_last/v_last, x=0, y=0, addr=0, stay SCAN (no bubble).
  - else: go IDLE, done=1 next cycle.
- stop sampled only on last-beat acceptance; mid-frame stop has no effect until then.
- start in SCAN ignored; size inputs changed mid-frame have no effect until next frame start.
- h_last=0 / v_last=0 legal (1-pixel line / 1-line frame). Max sizes all-ones: addr reaches 2^A_W-1 and wraps to 0 at frame restart, never overflows mid-frame.
- Reset mid-scan: immediately IDLE, all outputs 0; no done pulse.

## Timing
- Reset values: out_valid=0, x=0, y=0, addr=0, busy=0, done=0, all flags 0.
- All outputs registered.
- start at edge N -> out_valid=1 with (0,0,0) after edge N; first beat acceptable in cycle N+1.
- Throughput: one beat per cycle while out_ready=1, including across frame boundaries in continuous mode.
- done: high exactly one cycle, the cycle after final acceptance; out_valid=0 and busy=0 that same cycle.
- start in the cycle done is high is accepted (state is IDLE).

## Configuration
- RASTER_ADDR_GEN_FLAGS_EN defined: ports sol (x==0), eol (x==h_last), sof (x==0 && y==0), eof (x==h_last && y==v_last) present, gated by out_valid, registered with the beat.
- Undefined: these ports and their logic absent; all other behaviour identical.

## Test plan
- Reset then start, cont=0, h_last=3, v_last=1, out_ready=1 -> 8 beats (x,y,addr) (0,0,0)..(3,1,7), then done pulse one cycle, out_valid=0.
- Same frame with out_ready toggled every other cycle -> outputs stable during stall, identical 8-beat sequence, done after 8th acceptance.
- cont=1, h_last=1, v_last=1, stop raised during 2nd frame -> frames back-to-back without bubble, sizes changed to h_last=2 before 2nd frame take effect at frame 2, IDLE after frame 2.
- h_last=0, v_last=0 single-shot -> exactly one beat (0,0,0), with flags macro sol=eol=sof=eof=1 on it.
- Max frame (all-ones, default widths) -> 2^20 beats, last beat x=1023, y=1023, addr=0xFFFFF, then done.
- Assert rst mid-scan (x=2,y=1) -> all outputs 0 asynchronously, no done; next start restarts at (0,0,0).

Source files
------------

// File: rtl/raster_addr_gen.sv
// Raster-scan X/Y and linear address generator with valid/ready output and single/continuous frame modes.
// Optional sol/eol/sof/eof beat flags are compiled in when RASTER_ADDR_GEN_FLAGS_EN is defined.
module raster_addr_gen #(
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int A_W = X_W + Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic           stop,
  input  logic [X_W-1:0] h_last,
  input  logic [Y_W-1:0] v_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [A_W-1:0] addr,
  output logic           busy,
  output logic           done
`ifdef RASTER_ADDR_GEN_FLAGS_EN
  ,
  output logic           sol,
  output logic           eol,
  output logic           sof,
  output logic           eof
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_n;
  logic [X_W-1:0] h_lim, h_n, x_n;
  logic [Y_W-1:0] v_lim, v_n, y_n;
  logic [A_W-1:0] addr_n;
  logic           cont_q, cont_n, done_n, valid_n;

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops and x/y/addr/flags never change until that happens.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    addr_n  = addr;
    h_n     = h_lim;
    v_n     = v_lim;
    cont_n  = cont_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          h_n     = h_last;
          v_n     = v_last;
          cont_n  = cont;
          x_n     = '0;
          y_n     = '0;
          addr_n  = '0;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (x != h_lim) begin
            x_n    = x + 1'b1;
            addr_n = addr + 1'b1;
          end else if (y != v_lim) begin
            x_n    = '0;
            y_n    = y + 1'b1;
            addr_n = addr + 1'b1;
          end else if (cont_q && !stop) begin
            // back-to-back frame: new geometry is taken on the last beat, no bubble
            h_n    = h_last;
            v_n    = v_last;
            x_n    = '0;
            y_n    = '0;
            addr_n = '0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            x_n     = '0;
            y_n     = '0;
            addr_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      h_lim     <= '0;
      v_lim     <= '0;
      cont_q    <= 1'b0;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      h_lim     <= h_n;
      v_lim     <= v_n;
      cont_q    <= cont_n;
      x         <= x_n;
      y         <= y_n;
      addr      <= addr_n;
      out_valid <= valid_n;
      busy      <= valid_n;
      done      <= done_n;
    end
  end

`ifdef RASTER_ADDR_GEN_FLAGS_EN
  // Flags are computed from the next beat so they register together with x/y/addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sol <= 1'b0;
      eol <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
    end else begin
      sol <= valid_n && (x_n == '0);
      eol <= valid_n && (x_n == h_n);
      sof <= valid_n && (x_n == '0) && (y_n == '0);
      eof <= valid_n && (x_n == h_n) && (y_n == v_n);
    end
  end
`endif

endmodule
